// File: rtl/checkbits_mark_monitor.sv
// Checkbits start/finish mark monitor: synchronises and debounces the GPIO word, times the FIR run
// between marks and captures the last result. Optional history FIFO enabled by CHECKBITS_HISTORY_EN.
module checkbits_mark_monitor #(
  parameter int              DW            = 16,
  parameter logic [DW-1:0]   START_MARK    = 16'hA5A5,
  parameter logic [DW-1:0]   FINISH_MARK   = 16'h5A5A,
  parameter int              STABLE_CYCLES = 4,
  parameter int              CNT_W         = 32
) (
  input  logic             clk,
  input  logic             RSTB,
  input  logic [DW-1:0]    checkbits_i,
  input  logic             enable_i,
  input  logic             clear_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] latency_o,
  output logic [DW-1:0]    result_o,
  output logic             result_valid_o,
  output logic             err_o,
  output logic [1:0]       err_code_o,
  output logic [7:0]       run_count_o
`ifdef CHECKBITS_HISTORY_EN
  ,
  input  logic             hist_rd_i,
  output logic [DW-1:0]    hist_data_o,
  output logic             hist_empty_o,
  output logic             hist_ovf_o
`endif
);

  localparam int STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_PRE  = {{(CNT_W-1){1'b1}}, 1'b0};

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic [DW-1:0]     sync1_r, sync2_r, prev_r, acc_val_r;
  logic [STAB_W-1:0] stab_r, stab_nxt_s;
  logic              acc_evt_r, accept_s;
  state_t            state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, latency_r;
  logic [DW-1:0]     last_val_r, result_r;
  logic              last_seen_r, result_valid_r, busy_r, done_r, err_r;
  logic [1:0]        err_code_r, err_code_s;
  logic [7:0]        run_count_r;
  logic              start_s, finish_s, data_s, done_s, err_set_s;

  // Stability counter next value and accept decision
  always_comb begin
    stab_nxt_s = stab_r;
    if (sync2_r != prev_r) stab_nxt_s = '0;
    else if (stab_r != STAB_MAX) stab_nxt_s = stab_r + STAB_W'(1);
    else stab_nxt_s = stab_r;
    accept_s = (stab_nxt_s == STAB_MAX) && (sync2_r != acc_val_r);
  end

  // Synchroniser and debounce filter; untouched by clear and enable so no stale value replays
  always_ff @(posedge clk or negedge RSTB) begin
    if (!RSTB) begin
      sync1_r   <= '0;
      sync2_r   <= '0;
      prev_r    <= '0;
      stab_r    <= '0;
      acc_val_r <= '0;
      acc_evt_r <= 1'b0;
    end else begin
      sync1_r   <= checkbits_i;
      sync2_r   <= sync1_r;
      prev_r    <= sync2_r;
      stab_r    <= stab_nxt_s;
      acc_evt_r <= accept_s;
      if (accept_s) acc_val_r <= sync2_r;
    end
  end

  assign start_s  = acc_evt_r && (acc_val_r == START_MARK);
  assign finish_s = acc_evt_r && (acc_val_r == FINISH_MARK);
  assign data_s   = acc_evt_r && !start_s && !finish_s;

  // FSM state register
  always_ff @(posedge clk or negedge RSTB) begin
    if (!RSTB) state_r <= ST_IDLE;
    else state_r <= state_nxt_s;
  end

  // FSM next state
  always_comb begin
    state_nxt_s = state_r;
    if (clear_i || !enable_i) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: if (start_s) state_nxt_s = ST_RUN; else state_nxt_s = ST_IDLE;
        ST_RUN:  if (finish_s) state_nxt_s = ST_IDLE; else state_nxt_s = ST_RUN;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // FSM output decode: done pulse and error cause
  always_comb begin
    done_s     = 1'b0;
    err_set_s  = 1'b0;
    err_code_s = 2'b00;
    if (!clear_i && enable_i) begin
      case (state_r)
        ST_IDLE: begin
          if (finish_s) begin err_set_s = 1'b1; err_code_s = 2'b01; end
          else err_set_s = 1'b0;
        end
        ST_RUN: begin
          if (start_s) begin err_set_s = 1'b1; err_code_s = 2'b10; end
          else if (finish_s) done_s = 1'b1;
          else if (cnt_r == CNT_PRE) begin err_set_s = 1'b1; err_code_s = 2'b11; end
          else done_s = 1'b0;
        end
        default: done_s = 1'b0;
      endcase
    end else begin
      done_s = 1'b0;
    end
  end

  // Run counter, capture registers and sticky first-error record
  always_ff @(posedge clk or negedge RSTB) begin
    if (!RSTB || clear_i) begin
      cnt_r <= '0; latency_r <= '0; last_val_r <= '0; last_seen_r <= 1'b0;
      result_r <= '0; result_valid_r <= 1'b0; busy_r <= 1'b0; done_r <= 1'b0;
      err_r <= 1'b0; err_code_r <= 2'b00; run_count_r <= 8'd0;
    end else if (!enable_i) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s == ST_RUN);
      done_r <= done_s;
      if (err_set_s && !err_r) begin
        err_r      <= 1'b1;
        err_code_r <= err_code_s;
      end
      if (start_s) begin
        cnt_r       <= '0;
        last_val_r  <= '0;
        last_seen_r <= 1'b0;
      end else if (done_s) begin
        latency_r      <= sat_inc(cnt_r);
        result_r       <= last_val_r;
        result_valid_r <= last_seen_r;
        run_count_r    <= run_count_r + 8'd1;
      end else if (state_r == ST_RUN) begin
        cnt_r <= sat_inc(cnt_r);
        if (data_s) begin
          last_val_r  <= acc_val_r;
          last_seen_r <= 1'b1;
        end
      end
    end
  end

  assign busy_o         = busy_r;
  assign done_o         = done_r;
  assign latency_o      = latency_r;
  assign result_o       = result_r;
  assign result_valid_o = result_valid_r;
  assign err_o          = err_r;
  assign err_code_o     = err_code_r;
  assign run_count_o    = run_count_r;

`ifdef CHECKBITS_HISTORY_EN
  logic [DW-1:0] hist_mem_r [8];
  logic [2:0]    hist_wp_r, hist_rp_r;
  logic [3:0]    hist_cnt_r;
  logic          hist_ovf_r, hist_wr_s, hist_rd_s, hist_full_s, hist_wr_ok_s, hist_clr_s;

  assign hist_full_s  = (hist_cnt_r == 4'd8);
  assign hist_wr_s    = enable_i && !clear_i && (state_r == ST_RUN) && data_s;
  assign hist_rd_s    = hist_rd_i && (hist_cnt_r != 4'd0);
  assign hist_wr_ok_s = hist_wr_s && (!hist_full_s || hist_rd_s);
  assign hist_clr_s   = clear_i || (enable_i && start_s);

  // History FIFO of accepted data words within a run
  always_ff @(posedge clk or negedge RSTB) begin
    if (!RSTB) begin
      for (int i = 0; i < 8; i++) hist_mem_r[i] <= '0;
      hist_wp_r <= 3'd0; hist_rp_r <= 3'd0; hist_cnt_r <= 4'd0; hist_ovf_r <= 1'b0;
    end else if (hist_clr_s) begin
      hist_wp_r <= 3'd0; hist_rp_r <= 3'd0; hist_cnt_r <= 4'd0; hist_ovf_r <= 1'b0;
    end else begin
      if (hist_wr_ok_s) begin
        hist_mem_r[hist_wp_r] <= acc_val_r;
        hist_wp_r             <= hist_wp_r + 3'd1;
      end
      if (hist_rd_s) hist_rp_r <= hist_rp_r + 3'd1;
      if (hist_wr_s && !hist_wr_ok_s) hist_ovf_r <= 1'b1;
      case ({hist_wr_ok_s, hist_rd_s})
        2'b10:   hist_cnt_r <= hist_cnt_r + 4'd1;
        2'b01:   hist_cnt_r <= hist_cnt_r - 4'd1;
        default: hist_cnt_r <= hist_cnt_r;
      endcase
    end
  end

  assign hist_data_o  = hist_mem_r[hist_rp_r];
  assign hist_empty_o = (hist_cnt_r == 4'd0);
  assign hist_ovf_o   = hist_ovf_r;
`endif

endmodule

// File: tb/tb_checkbits_mark_monitor.sv
// Directed bench for checkbits_mark_monitor: reset, nominal timing, glitch, restart, overflow,
// enable gating and clear-versus-finish priority.
module tb_checkbits_mark_monitor;
  localparam int DW    = 16;
  localparam int CNT_W = 11;

  logic             clk = 1'b0;
  logic             RSTB, enable_i, clear_i;
  logic [DW-1:0]    checkbits_i;
  logic             busy_o, done_o, result_valid_o, err_o;
  logic [CNT_W-1:0] latency_o;
  logic [DW-1:0]    result_o;
  logic [1:0]       err_code_o;
  logic [7:0]       run_count_o;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int done_cnt  = 0;
  int base;

  checkbits_mark_monitor #(.DW(DW), .STABLE_CYCLES(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .RSTB(RSTB), .checkbits_i(checkbits_i), .enable_i(enable_i), .clear_i(clear_i),
    .busy_o(busy_o), .done_o(done_o), .latency_o(latency_o), .result_o(result_o),
    .result_valid_o(result_valid_o), .err_o(err_o), .err_code_o(err_code_o), .run_count_o(run_count_o)
  );

  always #5 clk = ~clk;

  // Count cycles in which done_o is high
  always @(posedge clk) if (done_o) done_cnt <= done_cnt + 1;

  task automatic drive(input logic [DW-1:0] v, input int cycles);
    checkbits_i = v;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic align;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear;
    align();
    clear_i = 1'b1;
    align();
    clear_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int b);
    int n = 0;
    while (done_cnt == b && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [40:0] all_s;
    all_s = {busy_o, done_o, latency_o, result_o, result_valid_o, err_o, err_code_o, run_count_o};
    total_cnt++;
    if (all_s !== 41'd0) $display("FAIL reset_outputs: got %h want 0", all_s); else pass_cnt++;
    drive(16'hA5A5, 20);
    total_cnt++;
    if (busy_o !== 1'b1) $display("FAIL reset_pre_busy: got %b want 1", busy_o); else pass_cnt++;
    #3 RSTB = 1'b0;
    #1;
    all_s = {busy_o, done_o, latency_o, result_o, result_valid_o, err_o, err_code_o, run_count_o};
    total_cnt++;
    if (all_s !== 41'd0) $display("FAIL reset_async: got %h want 0", all_s); else pass_cnt++;
    checkbits_i = 16'h0000;
    repeat (2) @(posedge clk);
    #1 RSTB = 1'b1;
    base = done_cnt;
    drive(16'h5A5A, 20);
    @(negedge clk);
    total_cnt++;
    if (done_cnt !== base) $display("FAIL reset_finish_idle_done: got %0d want 0", done_cnt - base); else pass_cnt++;
    total_cnt++;
    if ({err_o, err_code_o} !== 3'b101) $display("FAIL reset_finish_idle_err: got %b want 101", {err_o, err_code_o}); else pass_cnt++;
  endtask

  task automatic test_nominal;
    pulse_clear();
    total_cnt++;
    if ({err_o, err_code_o} !== 3'b000) $display("FAIL clear_err: got %b want 000", {err_o, err_code_o}); else pass_cnt++;
    drive(16'h0000, 10);
    base = done_cnt;
    drive(16'hA5A5, 1000);
    drive(16'h0028, 200);
    checkbits_i = 16'h5A5A;
    wait_done(40, base);
    total_cnt++;
    if (done_cnt - base !== 1) $display("FAIL nominal_done_pulse: got %0d want 1", done_cnt - base); else pass_cnt++;
    total_cnt++;
    if (latency_o !== 11'd1200) $display("FAIL nominal_latency: got %0d want 1200", latency_o); else pass_cnt++;
    total_cnt++;
    if ({result_valid_o, result_o} !== {1'b1, 16'h0028}) $display("FAIL nominal_result: got %b/%h want 1/0028", result_valid_o, result_o); else pass_cnt++;
    total_cnt++;
    if ({run_count_o, err_o, busy_o} !== {8'd1, 1'b0, 1'b0}) $display("FAIL nominal_status: got run=%0d err=%b busy=%b want 1/0/0", run_count_o, err_o, busy_o); else pass_cnt++;
  endtask

  task automatic test_glitch;
    align();
    base = done_cnt;
    drive(16'hA5A5, 20);
    drive(16'h5A5A, 2);
    drive(16'hA5A5, 20);
    total_cnt++;
    if (done_cnt !== base || busy_o !== 1'b1) $display("FAIL glitch_dropped: got done=%0d busy=%b want 0/1", done_cnt - base, busy_o); else pass_cnt++;
    drive(16'h5A5A, 4);
    checkbits_i = 16'h0000;
    wait_done(40, base);
    total_cnt++;
    if (done_cnt - base !== 1) $display("FAIL glitch_held_done: got %0d want 1", done_cnt - base); else pass_cnt++;
    total_cnt++;
    if (latency_o !== 11'd42) $display("FAIL glitch_latency: got %0d want 42", latency_o); else pass_cnt++;
    total_cnt++;
    if ({result_valid_o, result_o, run_count_o} !== {1'b0, 16'h0000, 8'd2}) $display("FAIL glitch_result: got %b/%h/%0d want 0/0000/2", result_valid_o, result_o, run_count_o); else pass_cnt++;
  endtask

  task automatic test_restart;
    pulse_clear();
    drive(16'h0000, 10);
    base = done_cnt;
    drive(16'hA5A5, 300);
    drive(16'h0000, 20);
    drive(16'hA5A5, 50);
    total_cnt++;
    if ({err_o, err_code_o, busy_o} !== 4'b1101) $display("FAIL restart_err: got %b want 1101", {err_o, err_code_o, busy_o}); else pass_cnt++;
    checkbits_i = 16'h5A5A;
    wait_done(40, base);
    total_cnt++;
    if (latency_o !== 11'd50) $display("FAIL restart_latency: got %0d want 50", latency_o); else pass_cnt++;
    total_cnt++;
    if ({result_valid_o, run_count_o, done_cnt - base} !== {1'b0, 8'd1, 32'd1}) $display("FAIL restart_result: got rv=%b run=%0d done=%0d want 0/1/1", result_valid_o, run_count_o, done_cnt - base); else pass_cnt++;
  endtask

  task automatic test_overflow;
    pulse_clear();
    drive(16'h0000, 10);
    base = done_cnt;
    drive(16'hA5A5, 2100);
    total_cnt++;
    if ({err_o, err_code_o, busy_o} !== 4'b1111) $display("FAIL overflow_err: got %b want 1111", {err_o, err_code_o, busy_o}); else pass_cnt++;
    checkbits_i = 16'h5A5A;
    wait_done(40, base);
    total_cnt++;
    if (done_cnt - base !== 1) $display("FAIL overflow_done: got %0d want 1", done_cnt - base); else pass_cnt++;
    total_cnt++;
    if (latency_o !== 11'd2047) $display("FAIL overflow_latency: got %0d want 2047", latency_o); else pass_cnt++;
  endtask

  task automatic test_enable;
    align();
    base = done_cnt;
    enable_i = 1'b0;
    drive(16'hA5A5, 20);
    total_cnt++;
    if (busy_o !== 1'b0 || latency_o !== 11'd2047) $display("FAIL disable_hold: got busy=%b lat=%0d want 0/2047", busy_o, latency_o); else pass_cnt++;
    enable_i = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (busy_o !== 1'b0 || done_cnt !== base) $display("FAIL reenable_no_replay: got busy=%b done=%0d want 0/0", busy_o, done_cnt - base); else pass_cnt++;
  endtask

  task automatic test_clear_event;
    logic [40:0] all_s;
    pulse_clear();
    drive(16'h0000, 10);
    drive(16'hA5A5, 30);
    total_cnt++;
    if (busy_o !== 1'b1) $display("FAIL clrevt_busy: got %b want 1", busy_o); else pass_cnt++;
    base = done_cnt;
    checkbits_i = 16'h5A5A;
    repeat (5) @(posedge clk);
    #1 clear_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 clear_i = 1'b0;
    repeat (10) @(negedge clk);
    total_cnt++;
    if (done_cnt !== base) $display("FAIL clrevt_no_done: got %0d want 0", done_cnt - base); else pass_cnt++;
    all_s = {busy_o, done_o, latency_o, result_o, result_valid_o, err_o, err_code_o, run_count_o};
    total_cnt++;
    if (all_s !== 41'd0) $display("FAIL clrevt_outputs: got %h want 0", all_s); else pass_cnt++;
  endtask

  initial begin
    RSTB = 1'b0;
    enable_i = 1'b1;
    clear_i = 1'b0;
    checkbits_i = 16'h0000;
    repeat (3) @(posedge clk);
    #1 RSTB = 1'b1;
    align();
    test_reset();
    test_nominal();
    test_glitch();
    test_restart();
    test_overflow();
    test_enable();
    test_clear_event();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
